// File: rtl/multicycle_controller.sv
// Multicycle RISC-V sequencing FSM: per-cycle control steps, memory-ready handshake, retire counter.
// Optional MC_ILLEGAL_TRAP_EN: unknown opcodes in DECODE park the FSM in an absorbing ERROR state.
module multicycle_controller (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  op,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic        Zero,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        AdrSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [2:0]  ALUControl,
   output logic        instr_done,
   output logic [31:0] instret,
   output logic [3:0]  state
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
      EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, ERROR = 4'd15
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;

   typedef struct packed {
      logic       adr;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [1:0] res;
      logic [2:0] alu;
      logic       pc_write;
      logic       mem_write;
      logic       reg_write;
      logic       done;
   } ctl_t;

   state_t cur, nxt;
   ctl_t   ctl;

   function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
      case (f3)
         3'b000:  alu_dec = sub ? ALU_SUB : ALU_ADD;
         3'b100:  alu_dec = ALU_XOR;
         3'b110:  alu_dec = ALU_OR;
         3'b111:  alu_dec = ALU_AND;
         3'b001:  alu_dec = ALU_SLL;
         3'b101:  alu_dec = ALU_SRL;
         default: alu_dec = ALU_ADD;
      endcase
   endfunction

   // Unconditional (Moore) part of the controls for a state; the mem_ready/Zero
   // qualified enables are added combinationally below.
   function automatic ctl_t ctl_of(input state_t s, input logic [2:0] f3, input logic f7b5);
      ctl_t c;
      c = '0;
      case (s)
         FETCH:    begin c.src_b = 2'b10; c.res = 2'b10; end
         DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
         MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
         MEMREAD:  c.adr = 1'b1;
         MEMWB:    begin c.res = 2'b01; c.reg_write = 1'b1; c.done = 1'b1; end
         MEMWRITE: begin c.adr = 1'b1; c.mem_write = 1'b1; end
         EXECR:    begin c.src_a = 2'b10; c.alu = alu_dec(f3, f7b5); end
         EXECI:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu = alu_dec(f3, 1'b0); end
         ALUWB:    begin c.reg_write = 1'b1; c.done = 1'b1; end
         BEQ:      begin c.src_a = 2'b10; c.alu = ALU_SUB; c.done = 1'b1; end
         JAL:      begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_write = 1'b1; end
         default:  c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      nxt = cur;
      case (cur)
         FETCH:    if (mem_ready) nxt = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: nxt = MEMADR;
               OP_R:         nxt = EXECR;
               OP_I:         nxt = EXECI;
               OP_BEQ:       nxt = BEQ;
               OP_JAL:       nxt = JAL;
`ifdef MC_ILLEGAL_TRAP_EN
               default:      nxt = ERROR;
`else
               default:      nxt = FETCH;
`endif
            endcase
         end
         MEMADR:   nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD:  if (mem_ready) nxt = MEMWB;
         MEMWRITE: if (mem_ready) nxt = FETCH;
         EXECR, EXECI, JAL: nxt = ALUWB;
         MEMWB, ALUWB, BEQ: nxt = FETCH;
         ERROR:    nxt = ERROR;
         default:  nxt = FETCH;
      endcase
   end

   // Controls are registered for the state being entered, so they are glitch-free
   // and reset asynchronously along with the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur     <= FETCH;
         ctl     <= ctl_of(FETCH, 3'b000, 1'b0);
         instret <= '0;
      end else begin
         cur <= nxt;
         ctl <= ctl_of(nxt, funct3, funct7b5);
         if (instr_done) instret <= instret + 32'd1;
      end
   end

   // FETCH is the reset state, so its handshake-qualified enables need an explicit reset gate.
   assign IRWrite    = rst && (cur == FETCH) && mem_ready;
   assign PCWrite    = ctl.pc_write || IRWrite || ((cur == BEQ) && Zero);
   assign MemWrite   = ctl.mem_write;
   assign RegWrite   = ctl.reg_write;
   assign instr_done = ctl.done || ((cur == MEMWRITE) && mem_ready);
   assign AdrSrc     = ctl.adr;
   assign ALUSrcA    = ctl.src_a;
   assign ALUSrcB    = ctl.src_b;
   assign ResultSrc  = ctl.res;
   assign ALUControl = ctl.alu;
   assign state      = cur;

   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors are queued
// as stimulus is applied and popped against the DUT at the falling edge.
module tb_multicycle_controller;
   logic        clk = 1'b0;
   logic        rst, Zero, mem_ready, funct7b5;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, instr_done;
   logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0]  ALUControl;
   logic [31:0] instret;
   logic [3:0]  state;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_ret = '0;
   logic [18:0] sb [$];

   localparam logic [4:0] EN0  = 5'b00000;  // {PCWrite, IRWrite, MemWrite, RegWrite, instr_done}
   localparam logic [4:0] EN_F = 5'b11000;
   localparam logic [4:0] EN_W = 5'b00011;
   localparam logic [2:0] ADD  = 3'b000;

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instr_done(instr_done),
      .instret(instret), .state(state)
   );

   function automatic logic [18:0] obs();
      return {state, PCWrite, IRWrite, MemWrite, RegWrite, instr_done,
              AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl};
   endfunction

   // Expected vector: datapath selects follow the per-state table {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}.
   function automatic logic [18:0] mk(input logic [3:0] st, input logic [4:0] en, input logic [2:0] alu);
      logic [6:0] sel;
      case (st)
         4'd0:    sel = 7'b0_00_10_10;
         4'd1:    sel = 7'b0_01_01_00;
         4'd2:    sel = 7'b0_10_01_00;
         4'd3:    sel = 7'b1_00_00_00;
         4'd4:    sel = 7'b0_00_00_01;
         4'd5:    sel = 7'b1_00_00_00;
         4'd6:    sel = 7'b0_10_00_00;
         4'd7:    sel = 7'b0_10_01_00;
         4'd9:    sel = 7'b0_10_00_00;
         4'd10:   sel = 7'b0_01_10_00;
         default: sel = 7'b0_00_00_00;
      endcase
      return {st, en, sel, alu};
   endfunction

   task automatic test_reset();
      rst = 1'b1; mem_ready = 1'b1; Zero = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
      #1 rst = 1'b0;
      #1;
      checks++;
      if (obs() !== mk(4'd0, EN0, ADD)) begin
         errors++; $display("FAIL reset_async: got %b want %b", obs(), mk(4'd0, EN0, ADD));
      end
      @(negedge clk);
      checks++;
      if (obs() !== mk(4'd0, EN0, ADD) || instret !== 32'd0) begin
         errors++; $display("FAIL reset_hold: got %b/%0d want %b/0", obs(), instret, mk(4'd0, EN0, ADD));
      end
      @(posedge clk); #1 rst = 1'b1;
   endtask

   task automatic test_lw();
      logic [18:0] ex [5];
      logic [18:0] e;
      op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
      ex = '{mk(4'd0, EN_F, ADD), mk(4'd1, EN0, ADD), mk(4'd2, EN0, ADD),
             mk(4'd3, EN0, ADD), mk(4'd4, EN_W, ADD)};
      for (int i = 0; i < 5; i++) begin
         sb.push_back(ex[i]);
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (obs() !== e) begin errors++; $display("FAIL lw cyc%0d: got %b want %b", i, obs(), e); end
         @(posedge clk); #1;
      end
      exp_ret++; checks++;
      if (instret !== exp_ret) begin errors++; $display("FAIL lw_instret: got %0d want %0d", instret, exp_ret); end
      checks++;
      if (ImmSrc !== 2'b00) begin errors++; $display("FAIL lw_imm: got %b want 00", ImmSrc); end
   endtask

   task automatic test_fetch_stall();
      logic [18:0] ex [7];
      logic        mr [7];
      logic [18:0] e;
      op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
      mr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      ex = '{mk(4'd0, EN0, ADD), mk(4'd0, EN0, ADD), mk(4'd0, EN0, ADD), mk(4'd0, EN_F, ADD),
             mk(4'd1, EN0, ADD), mk(4'd7, EN0, ADD), mk(4'd8, EN_W, ADD)};
      for (int i = 0; i < 7; i++) begin
         mem_ready = mr[i];
         sb.push_back(ex[i]);
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (obs() !== e) begin errors++; $display("FAIL stall_addi cyc%0d: got %b want %b", i, obs(), e); end
         @(posedge clk); #1;
      end
      exp_ret++; checks++;
      if (instret !== exp_ret) begin errors++; $display("FAIL stall_instret: got %0d want %0d", instret, exp_ret); end
   endtask

   task automatic test_rtype();
      logic [2:0]  f3  [3];
      logic        f7  [3];
      logic [2:0]  alu [3];
      logic [18:0] e;
      f3 = '{3'b000, 3'b111, 3'b101}; f7 = '{1'b1, 1'b0, 1'b1}; alu = '{3'b001, 3'b010, 3'b110};
      op = 7'b0110011; mem_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         funct3 = f3[k]; funct7b5 = f7[k];
         sb.push_back(mk(4'd0, EN_F, ADD)); sb.push_back(mk(4'd1, EN0, ADD));
         sb.push_back(mk(4'd6, EN0, alu[k])); sb.push_back(mk(4'd8, EN_W, ADD));
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL rtype%0d cyc%0d: got %b want %b", k, i, obs(), e); end
            @(posedge clk); #1;
         end
         exp_ret++;
      end
      checks++;
      if (instret !== exp_ret) begin errors++; $display("FAIL rtype_instret: got %0d want %0d", instret, exp_ret); end
   endtask

   task automatic test_beq();
      logic [18:0] e;
      op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
      for (int z = 1; z >= 0; z--) begin
         Zero = (z == 1);
         sb.push_back(mk(4'd0, EN_F, ADD)); sb.push_back(mk(4'd1, EN0, ADD));
         sb.push_back(mk(4'd9, (z == 1) ? 5'b10001 : 5'b00001, 3'b001));
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL beq_z%0d cyc%0d: got %b want %b", z, i, obs(), e); end
            @(posedge clk); #1;
         end
         exp_ret++;
      end
      Zero = 1'b0;
      checks++;
      if (instret !== exp_ret || ImmSrc !== 2'b10) begin
         errors++; $display("FAIL beq_instret_imm: got %0d/%b want %0d/10", instret, ImmSrc, exp_ret);
      end
   endtask

   task automatic test_jal();
      logic [18:0] e;
      op = 7'b1101111; mem_ready = 1'b1;
      sb.push_back(mk(4'd0, EN_F, ADD)); sb.push_back(mk(4'd1, EN0, ADD));
      sb.push_back(mk(4'd10, 5'b10000, ADD)); sb.push_back(mk(4'd8, EN_W, ADD));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (obs() !== e) begin errors++; $display("FAIL jal cyc%0d: got %b want %b", i, obs(), e); end
         @(posedge clk); #1;
      end
      exp_ret++; checks++;
      if (instret !== exp_ret || ImmSrc !== 2'b11) begin
         errors++; $display("FAIL jal_instret_imm: got %0d/%b want %0d/11", instret, ImmSrc, exp_ret);
      end
   endtask

   task automatic test_illegal();
      logic [18:0] e;
      op = 7'b0000000; mem_ready = 1'b1;
      sb.push_back(mk(4'd0, EN_F, ADD)); sb.push_back(mk(4'd1, EN0, ADD));
`ifdef MC_ILLEGAL_TRAP_EN
      sb.push_back(mk(4'd15, EN0, ADD)); sb.push_back(mk(4'd15, EN0, ADD));
`else
      sb.push_back(mk(4'd0, EN_F, ADD)); sb.push_back(mk(4'd1, EN0, ADD));
`endif
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (obs() !== e) begin errors++; $display("FAIL illegal cyc%0d: got %b want %b", i, obs(), e); end
         @(posedge clk); #1;
      end
      checks++;
      if (instret !== exp_ret) begin errors++; $display("FAIL illegal_instret: got %0d want %0d", instret, exp_ret); end
      rst = 1'b0;
      #1;
      exp_ret = '0; checks++;
      if (obs() !== mk(4'd0, EN0, ADD) || instret !== exp_ret) begin
         errors++; $display("FAIL illegal_reset: got %b/%0d want %b/0", obs(), instret, mk(4'd0, EN0, ADD));
      end
      @(posedge clk); #1 rst = 1'b1;
   endtask

   task automatic test_sw_reset();
      logic [18:0] ex [6];
      logic        mr [6];
      logic [18:0] e;
      op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
      mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      ex = '{mk(4'd0, EN_F, ADD), mk(4'd1, EN0, ADD), mk(4'd2, EN0, ADD),
             mk(4'd5, 5'b00100, ADD), mk(4'd5, 5'b00100, ADD), mk(4'd5, 5'b00101, ADD)};
      for (int i = 0; i < 6; i++) begin
         mem_ready = mr[i];
         sb.push_back(ex[i]);
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (obs() !== e) begin errors++; $display("FAIL sw_stall cyc%0d: got %b want %b", i, obs(), e); end
         @(posedge clk); #1;
      end
      exp_ret++; checks++;
      if (instret !== exp_ret || ImmSrc !== 2'b01) begin
         errors++; $display("FAIL sw_instret_imm: got %0d/%b want %0d/01", instret, ImmSrc, exp_ret);
      end
      // Second store is cut short by reset in its second MEMWRITE cycle.
      for (int i = 0; i < 4; i++) begin
         mem_ready = mr[i];
         sb.push_back(ex[i]);
         @(negedge clk);
         e = sb.pop_front(); checks++;
         if (obs() !== e) begin errors++; $display("FAIL sw_cut cyc%0d: got %b want %b", i, obs(), e); end
         @(posedge clk); #1;
      end
      #1;
      checks++;
      if (obs() !== mk(4'd5, 5'b00100, ADD)) begin
         errors++; $display("FAIL sw_pre_reset: got %b want %b", obs(), mk(4'd5, 5'b00100, ADD));
      end
      rst = 1'b0;
      #1;
      exp_ret = '0; checks++;
      if (obs() !== mk(4'd0, EN0, ADD) || instret !== exp_ret) begin
         errors++; $display("FAIL sw_mid_reset: got %b/%0d want %b/0", obs(), instret, mk(4'd0, EN0, ADD));
      end
      @(posedge clk); #1 rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_lw();
      test_fetch_stall();
      test_rtype();
      test_beq();
      test_jal();
      test_illegal();
      test_sw_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach the end of the sequence");
      $fatal(1);
   end
endmodule
